serial_pattern_gen: RTL and testbench
=====================================

// Module: serial_pattern_gen
// PURPOSE
//  Serial bit-stream transmitter: the driving end for the serial sequence detectors.
//  - Latches a PAT_W-bit pattern on a start request.
//  - Shifts the pattern out MSB first, one bit per clock, with a qualifying valid strobe.
//  - Repeats the pattern a programmable number of times, with programmable idle gap cycles.
//  - Used as the stimulus source feeding the x input of moore_1011_detector and its siblings.
// PARAMETERS
//  PAT_W  4  pattern width in bits (>=2)
//  REP_W  4  width of repetition-count input
//  GAP_W  3  width of inter-repetition gap input
// PORTS
//  clk      in   1      clock, all state updates on rising edge
//  reset_n  in   1      asynchronous, active-low reset
//  start    in   1      request a transmission; sampled only in IDLE
//  abort    in   1      synchronous cancel of the transmission in progress
//  pattern  in   PAT_W  bits to send, MSB first; latched at start
//  reps     in   REP_W  number of pattern repetitions; latched at start
//  gap      in   GAP_W  idle cycles between repetitions; latched at start
//  x        out  1      serial data bit; 0 whenever x_valid=0
//  x_valid  out  1      x carries a pattern bit this cycle
//  busy     out  1      transmission in progress; start is ignored
//  done     out  1      1-cycle pulse at normal completion
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE. x, x_valid, busy and done are all 0 immediately.
//    Shift register and counters are cleared.
//  - All outputs are registered. States: IDLE, SEND, GAP, DONE.
//  - IDLE, start=1 at edge k:
//    - Latch pattern, reps and gap.
//    - reps!=0: enter SEND. The first bit (pattern[PAT_W-1]) is on x with x_valid=1 and busy=1 from edge k+1.
//    - reps==0: enter DONE. done=1 for the cycle after edge k; no bits are sent.
//  - SEND:
//    - Each cycle outputs the next bit, MSB to LSB. The bit counter runs PAT_W-1 down to 0.
//    - After the LSB with repetitions remaining and gap!=0: enter GAP.
//    - After the LSB with repetitions remaining and gap==0: next repetition starts the following cycle, back-to-back.
//    - After the LSB of the last repetition: enter DONE.
//  - GAP: exactly gap cycles with x_valid=0, x=0 and busy=1, then SEND with the MSB.
//  - DONE: exactly 1 cycle with done=1, busy=0, x_valid=0. Then IDLE. start is ignored in DONE.
//  - A single transmission of R reps gives R*PAT_W valid cycles plus (R-1)*gap gap cycles.
//  - busy=1 in SEND and GAP only.
//  - start while busy or in DONE is ignored. Input changes while busy have no effect (latched copies are used).
//  - abort=1 in SEND or GAP:
//    - State goes to IDLE at the next edge, with x_valid=0 and busy=0.
//    - No done pulse.
//    - abort has priority over start in the same cycle.
//    - abort in IDLE or DONE has no effect.
//  - The repetition counter decrements at each LSB. The counter is REP_W bits wide, so the maximum is 2^REP_W-1 reps; no wrap occurs.
//  - reset_n asserted mid-SEND or mid-GAP: transmission is lost. After release, the block waits in IDLE for a new start.
// TESTING
//  1. pattern=4'b1011, reps=1, gap=0, start pulse
//     -> x=1,0,1,1 with x_valid=1 on 4 consecutive cycles, then done=1 for 1 cycle.
//     -> moore_1011_detector z asserts once.
//  2. pattern=4'b1011, reps=2, gap=0
//     -> 8 contiguous valid bits 10111011; busy=1 for 8 cycles; detector z asserts twice.
//  3. pattern=4'b1011, reps=2, gap=2
//     -> 1011, 2 cycles of x_valid=0 and x=0, then 1011; busy=1 for 10 cycles; single done.
//  4. reps=0, start
//     -> x_valid stays 0, busy stays 0; done=1 exactly 1 cycle after start.
//  5. reps=3: pulse start again mid-SEND (ignored), then abort after the 2nd bit
//     -> x_valid=0 and busy=0 next cycle; no done; a new start then sends normally.
//  6. reset_n=0 during GAP of a reps=3 run
//     -> x, x_valid, busy and done are 0 before the next clock edge; the block stays IDLE after release.

Source files
------------

// File: rtl/serial_pattern_gen.sv
// rtl/serial_pattern_gen.sv - serial bit-stream transmitter, MSB first, with repeat count and idle gaps
// Latched pattern/reps/gap drive a four-state SEND/GAP sequencer; every output is a flop.
module serial_pattern_gen #(
   parameter int PAT_W = 4,
   parameter int REP_W = 4,
   parameter int GAP_W = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] pattern,
   input  logic [REP_W-1:0] reps,
   input  logic [GAP_W-1:0] gap,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state;
   logic [PAT_W-1:0] pat_q;
   logic [PAT_W-1:0] shreg;
   logic [CNT_W-1:0] bit_cnt;
   logic [REP_W-1:0] rep_cnt;
   logic [GAP_W-1:0] gap_q;
   logic [GAP_W-1:0] gap_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         pat_q   <= '0;
         shreg   <= '0;
         bit_cnt <= '0;
         rep_cnt <= '0;
         gap_q   <= '0;
         gap_cnt <= '0;
         x       <= 1'b0;
         x_valid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  pat_q   <= pattern;
                  gap_q   <= gap;
                  rep_cnt <= reps;
                  if (reps != '0) begin
                     state   <= S_SEND;
                     x       <= pattern[PAT_W-1];
                     shreg   <= {pattern[PAT_W-2:0], 1'b0};
                     bit_cnt <= CNT_W'(PAT_W - 1);
                     x_valid <= 1'b1;
                     busy    <= 1'b1;
                  end else begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            S_SEND: begin
               if (abort) begin
                  state   <= S_IDLE;
                  x       <= 1'b0;
                  x_valid <= 1'b0;
                  busy    <= 1'b0;
               end else if (bit_cnt == '0) begin
                  // LSB is on the wire now: one repetition finished
                  rep_cnt <= rep_cnt - REP_W'(1);
                  if (rep_cnt == REP_W'(1)) begin
                     state   <= S_DONE;
                     x       <= 1'b0;
                     x_valid <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else if (gap_q != '0) begin
                     state   <= S_GAP;
                     gap_cnt <= gap_q;
                     x       <= 1'b0;
                     x_valid <= 1'b0;
                  end else begin
                     x       <= pat_q[PAT_W-1];
                     shreg   <= {pat_q[PAT_W-2:0], 1'b0};
                     bit_cnt <= CNT_W'(PAT_W - 1);
                  end
               end else begin
                  x       <= shreg[PAT_W-1];
                  shreg   <= {shreg[PAT_W-2:0], 1'b0};
                  bit_cnt <= bit_cnt - CNT_W'(1);
               end
            end
            S_GAP: begin
               if (abort) begin
                  state   <= S_IDLE;
                  x       <= 1'b0;
                  x_valid <= 1'b0;
                  busy    <= 1'b0;
               end else if (gap_cnt == GAP_W'(1)) begin
                  state   <= S_SEND;
                  x       <= pat_q[PAT_W-1];
                  shreg   <= {pat_q[PAT_W-2:0], 1'b0};
                  bit_cnt <= CNT_W'(PAT_W - 1);
                  x_valid <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb/tb_serial_pattern_gen.sv - randomized bench for serial_pattern_gen against a cycle-list model
module tb_serial_pattern_gen;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] pattern = '0;
   logic [3:0] reps = '0;
   logic [2:0] gap = '0;
   logic       x, x_valid, busy, done;

   int checks = 0;
   int errors = 0;

   serial_pattern_gen #(.PAT_W(4), .REP_W(4), .GAP_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .pattern(pattern), .reps(reps), .gap(gap),
      .x(x), .x_valid(x_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] outs();
      return {x, x_valid, busy, done};
   endfunction

   // Expected {x,x_valid,busy,done} per cycle after the start edge, built from the transmission rules.
   task automatic build(input logic [3:0] p, input int r, input int g, output logic [3:0] q[$]);
      q = {};
      for (int k = 0; k < r; k++) begin
         for (int b = 3; b >= 0; b--) q.push_back({p[b], 1'b1, 1'b1, 1'b0});
         if (k < r - 1)
            for (int j = 0; j < g; j++) q.push_back(4'b0010);
      end
      q.push_back(4'b0001);
   endtask

   task automatic run(input string name, input logic [3:0] p, input logic [3:0] r,
                      input logic [2:0] g, input int abort_at, input bit abort_in_idle);
      logic [3:0] q[$];
      build(p, int'(r), int'(g), q);
      pattern = p; reps = r; gap = g; start = 1'b1; abort = abort_in_idle;
      for (int i = 0; i < q.size(); i++) begin
         step();
         start = 1'b0; abort = 1'b0;
         check($sformatf("%s cyc%0d", name, i), 32'(outs()), 32'(q[i]));
         if (i == abort_at) begin
            abort = 1'b1;
            start = 1'($urandom_range(0, 1));
            step();
            abort = 1'b0; start = 1'b0;
            check($sformatf("%s abort", name), 32'(outs()), 32'h0);
            step();
            check($sformatf("%s post-abort idle", name), 32'(outs()), 32'h0);
            return;
         end
         // stray start and input churn while busy or in DONE must not matter
         pattern = 4'($urandom); reps = 4'($urandom); gap = 3'($urandom);
         start = ($urandom_range(0, 2) == 0);
      end
      step();
      start = 1'b0;
      check($sformatf("%s idle", name), 32'(outs()), 32'h0);
   endtask

   initial begin
      logic [3:0] rp, rr;
      logic [2:0] rg;
      int nvalid, ab;

      #2;
      check("reset outs", 32'(outs()), 32'h0);
      step();
      check("reset held", 32'(outs()), 32'h0);
      reset_n = 1'b1;
      step();
      check("idle after release", 32'(outs()), 32'h0);

      run("t1_1011_r1", 4'b1011, 4'd1, 3'd0, -1, 1'b0);
      run("t2_1011_r2", 4'b1011, 4'd2, 3'd0, -1, 1'b0);
      run("t3_1011_r2g2", 4'b1011, 4'd2, 3'd2, -1, 1'b0);
      run("t4_r0", 4'b1111, 4'd0, 3'd5, -1, 1'b0);
      run("t5_abort", 4'b1011, 4'd3, 3'd1, 1, 1'b0);
      run("t5_restart", 4'b1011, 4'd1, 3'd0, -1, 1'b0);
      run("abort_in_idle", 4'b0110, 4'd2, 3'd1, -1, 1'b1);
      run("max_reps", 4'b1001, 4'd15, 3'd7, -1, 1'b0);
      run("abort_in_gap", 4'b1100, 4'd2, 3'd3, 5, 1'b0);

      // reset during GAP of a reps=3 run
      pattern = 4'b1101; reps = 4'd3; gap = 3'd2; start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         start = 1'b0;
         check($sformatf("t6 bit%0d", i), 32'(outs()), 32'({pattern[3 - i], 3'b110}));
      end
      step();
      check("t6 gap", 32'(outs()), 32'h2);
      reset_n = 1'b0;
      #1;
      check("t6 async reset", 32'(outs()), 32'h0);
      step();
      #2 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("t6 idle%0d", i), 32'(outs()), 32'h0);
      end

      for (int t = 0; t < 30; t++) begin
         rp = 4'($urandom);
         rr = (t % 10 == 9) ? 4'd15 : 4'($urandom_range(0, 5));
         rg = 3'($urandom);
         nvalid = int'(rr) * 4 + (int'(rr) > 0 ? (int'(rr) - 1) * int'(rg) : 0);
         ab = -1;
         if (nvalid > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(0, nvalid - 1);
         run($sformatf("rnd%0d", t), rp, rr, rg, ab, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) begin
            step();
            check($sformatf("rnd%0d gapidle", t), 32'(outs()), 32'h0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
